// File: rtl/pattern_gen_pkg.sv
// Shared types for the parametrised pattern generator: step modes, FSM states
// and default maximal-length tap masks (shift-left, feedback into bit 0).
package pattern_gen_pkg;

  typedef enum logic [1:0] {
    MODE_LFSR  = 2'd0,
    MODE_COUNT = 2'd1,
    MODE_WALK  = 2'd2,
    MODE_HOLD  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [2:0] TAPS_W3 = 3'b101;
  localparam logic [3:0] TAPS_W4 = 4'b1100;
  localparam logic [4:0] TAPS_W5 = 5'b10100;
  localparam logic [5:0] TAPS_W6 = 6'b110000;
  localparam logic [6:0] TAPS_W7 = 7'b1100000;
  localparam logic [7:0] TAPS_W8 = 8'b10111000;

endpackage

// File: rtl/pattern_lane.sv
// One pattern lane: seed load with zero-seed sanitising plus the four step functions.
// State changes one cycle after load/step; holds otherwise.
module pattern_lane
  import pattern_gen_pkg::*;
#(
  parameter int            W    = 4,
  parameter logic [W-1:0]  TAPS = 4'b1100,
  parameter logic [W-1:0]  SEED = 4'd1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] seed,
  input  logic         step,
  input  mode_e        mode,
  output logic [W-1:0] state
);

  // Reset comes up in LFSR mode, so a zero reset seed must be made non-zero too.
  localparam logic [W-1:0] SEED_SAFE = (SEED == '0) ? W'(1) : SEED;

  logic [W-1:0] seed_clean;
  logic [W-1:0] step_val;
  logic         feedback;

  // LFSR and walk both lock at zero; count and hold are fine with it.
  always_comb begin
    seed_clean = seed;
    if ((seed == '0) && ((mode == MODE_LFSR) || (mode == MODE_WALK)))
      seed_clean = W'(1);
  end

  assign feedback = ^(state & TAPS);

  always_comb begin
    step_val = state;
    case (mode)
      MODE_LFSR:  step_val = {state[W-2:0], feedback};
      MODE_COUNT: step_val = state + W'(1);
      MODE_WALK:  step_val = {state[W-2:0], state[W-1]};
      MODE_HOLD:  step_val = state;
      default:    step_val = state;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= SEED_SAFE;
    end else if (load) begin
      state <= seed_clean;
    end else if (step) begin
      state <= step_val;
    end
  end

endmodule

// File: rtl/pattern_gen_param.sv
// Three-lane stimulus source with start/abort/done control and a valid/ready output.
// start -> first valid 1 cycle; lanes and pat_idx advance only on out_valid&&out_ready.
module pattern_gen_param
  import pattern_gen_pkg::*;
#(
  parameter int                A_W      = 4,
  parameter int                B_W      = 4,
  parameter int                SEL_W    = 3,
  parameter logic [A_W-1:0]    TAPS_A   = 4'b1100,
  parameter logic [B_W-1:0]    TAPS_B   = 4'b1100,
  parameter logic [SEL_W-1:0]  TAPS_SEL = 3'b101,
  parameter logic [A_W-1:0]    SEED_A   = 4'd1,
  parameter logic [B_W-1:0]    SEED_B   = 4'd2,
  parameter logic [SEL_W-1:0]  SEED_SEL = 3'd1,
  parameter int                CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       cfg_mode,
  input  logic             seed_load,
  input  logic [A_W-1:0]   seed_a,
  input  logic [B_W-1:0]   seed_b,
  input  logic [SEL_W-1:0] seed_sel,
  input  logic [CNT_W-1:0] num_patterns,
  input  logic             start,
  input  logic             abort,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [A_W-1:0]   A,
  output logic [B_W-1:0]   B,
  output logic [SEL_W-1:0] SEL,
  output logic [CNT_W-1:0] pat_idx,
  output logic             busy,
  output logic             done
);

  state_e           state;
  mode_e            mode_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] idx_next;
  logic             handshake;
  logic             lane_load;
  mode_e            lane_mode;

  // out_valid is only ever high in RUN, so the handshake alone gates stepping.
  assign handshake = out_valid && out_ready;
  assign lane_load = (state == ST_IDLE) && seed_load;
  assign idx_next  = pat_idx + CNT_W'(1);

  // Sanitising follows the mode about to be used; stepping follows the latched one.
  assign lane_mode = lane_load ? mode_e'(cfg_mode) : mode_q;

  pattern_lane #(.W(A_W), .TAPS(TAPS_A), .SEED(SEED_A)) u_lane_a (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (lane_load),
    .seed    (seed_a),
    .step    (handshake),
    .mode    (lane_mode),
    .state   (A)
  );

  pattern_lane #(.W(B_W), .TAPS(TAPS_B), .SEED(SEED_B)) u_lane_b (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (lane_load),
    .seed    (seed_b),
    .step    (handshake),
    .mode    (lane_mode),
    .state   (B)
  );

  pattern_lane #(.W(SEL_W), .TAPS(TAPS_SEL), .SEED(SEED_SEL)) u_lane_sel (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (lane_load),
    .seed    (seed_sel),
    .step    (handshake),
    .mode    (lane_mode),
    .state   (SEL)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      mode_q    <= MODE_LFSR;
      count_q   <= '0;
      pat_idx   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            mode_q    <= mode_e'(cfg_mode);
            count_q   <= num_patterns;
            pat_idx   <= '0;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (handshake)
            pat_idx <= idx_next;
          // Abort wins over a completing handshake: the run ends without done.
          if (abort) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end else if (handshake && (count_q != '0) && (idx_next == count_q)) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_gen_param.sv
// Scoreboard bench for pattern_gen_param: directed runs push hand-computed patterns,
// a negedge monitor pops and compares on every handshake.
module tb_pattern_gen_param;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  cfg_mode = 2'd0;
  logic        seed_load = 1'b0;
  logic [3:0]  seed_a = 4'd0;
  logic [3:0]  seed_b = 4'd0;
  logic [2:0]  seed_sel = 3'd0;
  logic [15:0] num_patterns = 16'd0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [3:0]  A;
  logic [3:0]  B;
  logic [2:0]  SEL;
  logic [15:0] pat_idx;
  logic        busy;
  logic        done;

  pattern_gen_param dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cfg_mode     (cfg_mode),
    .seed_load    (seed_load),
    .seed_a       (seed_a),
    .seed_b       (seed_b),
    .seed_sel     (seed_sel),
    .num_patterns (num_patterns),
    .start        (start),
    .abort        (abort),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .A            (A),
    .B            (B),
    .SEL          (SEL),
    .pat_idx      (pat_idx),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int s;
    int idx;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int hs_cnt = 0;
  int done_cnt = 0;

  // Hand-derived maximal sequences: 4-bit taps 1100 from 1, 3-bit taps 101 from 1.
  int la[15] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8};
  int ls[7]  = '{1, 3, 7, 6, 5, 2, 4};

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int a, input int b, input int s, input int idx);
    exp_t e;
    e.a = a; e.b = b; e.s = s; e.idx = idx;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("sb_unexpected_handshake", 1, 0);
        end else begin
          e = q.pop_front();
          check("sb_A", int'(A), e.a);
          check("sb_B", int'(B), e.b);
          check("sb_SEL", int'(SEL), e.s);
          check("sb_pat_idx", int'(pat_idx), e.idx);
        end
        hs_cnt++;
      end
      if (done) done_cnt++;
    end
  end

  task automatic start_run(input int mode, input int n, input bit sl,
                           input int sa, input int sb, input int ss);
    @(posedge clk); #1;
    cfg_mode = 2'(mode);
    num_patterns = 16'(n);
    seed_load = sl;
    seed_a = 4'(sa);
    seed_b = 4'(sb);
    seed_sel = 3'(ss);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seed_load = 1'b0;
  endtask

  task automatic wait_done(input string name, input int n, input int base);
    bit seen = 0;
    int k = 0;
    while (k < 60 && !seen) begin
      @(negedge clk);
      if (done) seen = 1;
      k++;
    end
    check({name, "_done_seen"}, int'(seen), 1);
    if (seen) begin
      check({name, "_transfers"}, hs_cnt - base, n);
      check({name, "_pat_idx"}, int'(pat_idx), n);
      check({name, "_valid_low"}, int'(out_valid), 0);
      check({name, "_busy_low"}, int'(busy), 0);
      @(negedge clk);
      check({name, "_done_one_cycle"}, int'(done), 0);
    end
    check({name, "_queue_empty"}, q.size(), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base;
    int d0;
    bit [4:0] rdy_tbl;

    // Reset values
    #12;
    check("rst_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_pat_idx", int'(pat_idx), 0);
    check("rst_A", int'(A), 1);
    check("rst_B", int'(B), 2);
    check("rst_SEL", int'(SEL), 1);
    #2 reset_n = 1'b1;

    // 1: LFSR from reset seeds, N=5
    out_ready = 1'b1;
    push(1, 2, 1, 0); push(2, 4, 3, 1); push(4, 9, 7, 2); push(9, 3, 6, 3); push(3, 6, 5, 4);
    base = hs_cnt;
    start_run(0, 5, 0, 0, 0, 0);
    check("t1_busy", int'(busy), 1);
    check("t1_valid", int'(out_valid), 1);
    wait_done("t1", 5, base);

    // 2a: count mode from E, wraps through 0
    @(posedge clk); #1;
    cfg_mode = 2'd1; seed_a = 4'hE; seed_b = 4'h0; seed_sel = 3'd6; seed_load = 1'b1;
    @(posedge clk); #1;
    seed_load = 1'b0;
    check("t2_loaded_A", int'(A), 14);
    check("t2_loaded_B_zero_kept", int'(B), 0);
    push(14, 0, 6, 0); push(15, 1, 7, 1); push(0, 2, 0, 2); push(1, 3, 1, 3);
    base = hs_cnt;
    start_run(1, 4, 0, 0, 0, 0);
    wait_done("t2a", 4, base);
    check("t2_A_after_run", int'(A), 2);

    // 2b: walk mode, zero seeds sanitised to 1
    push(1, 8, 1, 0); push(2, 1, 2, 1); push(4, 2, 4, 2); push(8, 4, 1, 3); push(1, 8, 2, 4);
    base = hs_cnt;
    start_run(2, 5, 1, 0, 8, 0);
    wait_done("t2b", 5, base);

    // 3: stalls with out_ready 1,0,0,1,1
    rdy_tbl = 5'b11001;
    out_ready = rdy_tbl[0];
    push(2, 1, 4, 0); push(4, 2, 1, 1); push(9, 4, 3, 2);
    base = hs_cnt;
    d0 = done_cnt;
    start_run(0, 3, 0, 0, 0, 0);
    for (int i = 1; i < 5; i++) begin
      @(posedge clk); #1;
      out_ready = rdy_tbl[i];
      if (!rdy_tbl[i]) begin
        #2;
        check("t3_stall_A", int'(A), 4);
        check("t3_stall_SEL", int'(SEL), 1);
        check("t3_stall_idx", int'(pat_idx), 1);
        check("t3_stall_done", done_cnt - d0, 0);
      end
    end
    wait_done("t3", 3, base);

    // 4: free-run, abort after 20 handshakes
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++)
      push(la[(4 + i) % 15], la[(3 + i) % 15], ls[(2 + i) % 7], i);
    base = hs_cnt;
    d0 = done_cnt;
    start_run(0, 0, 0, 0, 0, 0);
    repeat (20) @(posedge clk);
    #1;
    out_ready = 1'b0;
    abort = 1'b1;
    #3;
    check("t4_idx_before_abort", int'(pat_idx), 20);
    check("t4_valid_before_abort", int'(out_valid), 1);
    @(posedge clk); #1;
    abort = 1'b0;
    check("t4_valid_after_abort", int'(out_valid), 0);
    check("t4_busy_after_abort", int'(busy), 0);
    check("t4_idx_after_abort", int'(pat_idx), 20);
    repeat (3) @(negedge clk);
    check("t4_no_done", done_cnt - d0, 0);
    check("t4_transfers", hs_cnt - base, 20);
    check("t4_queue_empty", q.size(), 0);
    out_ready = 1'b1;
    push(11, 5, 3, 0); push(7, 11, 7, 1);
    base = hs_cnt;
    start_run(0, 2, 0, 0, 0, 0);
    wait_done("t4_cont", 2, base);

    // 5: start+seed_load together; start mid-run is ignored
    push(7, 3, 5, 0); push(15, 6, 2, 1); push(14, 13, 4, 2); push(12, 10, 1, 3);
    base = hs_cnt;
    start_run(0, 4, 1, 7, 3, 5);
    @(posedge clk); #1;
    start = 1'b1; seed_load = 1'b1; seed_a = 4'd0; cfg_mode = 2'd1; num_patterns = 16'd9;
    @(posedge clk); #1;
    start = 1'b0; seed_load = 1'b0;
    wait_done("t5", 4, base);

    // 6: asynchronous reset mid-run
    push(8, 5, 3, 0); push(1, 11, 7, 1); push(2, 7, 6, 2);
    base = hs_cnt;
    start_run(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("t6_rst_valid", int'(out_valid), 0);
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_idx", int'(pat_idx), 0);
    check("t6_rst_A", int'(A), 1);
    check("t6_rst_B", int'(B), 2);
    check("t6_rst_SEL", int'(SEL), 1);
    #10 reset_n = 1'b1;
    @(posedge clk); #1;
    check("t6_idle_valid", int'(out_valid), 0);
    check("t6_idle_busy", int'(busy), 0);
    check("t6_transfers", hs_cnt - base, 3);
    check("t6_queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
